// File: rtl/accel_ctrl_pkg.sv
// Shared types and bit positions for the accelerator run controller.
package accel_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SRST  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_NEXT  = 3'd4,
        ST_FIN   = 3'd5,
        ST_ABORT = 3'd6
    } state_e;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_SRST     = 1;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_ABORT    = 2;
    localparam int STAT_TMO      = 3;
    localparam int STAT_PASS_LSB = 16;

    // Core control bits {srst, en} driven while the FSM sits in a given state.
    function automatic logic [1:0] ctrl_bits(input state_e st);
        logic [1:0] bits;
        case (st)
            ST_SRST:  bits = 2'b10;
            ST_ABORT: bits = 2'b10;
            ST_RUN:   bits = 2'b01;
            default:  bits = 2'b00;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/accel_run_ctrl_if.sv
// Host/engine signal bundle for accel_run_ctrl; master = host side, slave = controller.
interface accel_run_ctrl_if #(
    parameter int REG_WIDTH  = 32,
    parameter int PASS_WIDTH = 16
);
    logic                  i_start;
    logic                  i_abort;
    logic [PASS_WIDTH-1:0] i_num_pass;
    logic                  i_kcpe_done;
    logic                  i_psum_done;
    logic                  i_irq_clr;
    logic [REG_WIDTH-1:0]  o_conf_ctrl;
    logic [PASS_WIDTH-1:0] o_pass_idx;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_irq;
    logic [REG_WIDTH-1:0]  o_status;

    modport master (
        output i_start, i_abort, i_num_pass, i_kcpe_done, i_psum_done, i_irq_clr,
        input  o_conf_ctrl, o_pass_idx, o_busy, o_done, o_irq, o_status
    );

    modport slave (
        input  i_start, i_abort, i_num_pass, i_kcpe_done, i_psum_done, i_irq_clr,
        output o_conf_ctrl, o_pass_idx, o_busy, o_done, o_irq, o_status
    );
endinterface

// File: rtl/accel_wdog_cnt.sv
// RUN-cycle watchdog: counts enabled cycles since the last clear, flags the LIMIT-th one.
module accel_wdog_cnt #(
    parameter int LIMIT = 1048576
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         at_lim_s;

    assign at_lim_s = (cnt_q == W'(LIMIT - 1));
    assign expire_o = en_i && at_lim_s;

    // Next count: clear wins, saturate at the limit so the counter never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {W{1'b0}};
        end else if (en_i && !at_lim_s) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/accel_run_ctrl.sv
// Multi-pass job sequencer for the conv core (soft reset, run, drain per pass).
// Optional RUN watchdog enabled by defining ACCEL_RUN_CTRL_WATCHDOG_EN.
module accel_run_ctrl
    import accel_ctrl_pkg::*;
#(
    parameter int REG_WIDTH   = 32,
    parameter int PASS_WIDTH  = 16,
    parameter int SRST_CYCLES = 2,
    parameter int WDOG_LIMIT  = 1048576
) (
    input  logic          clk,
    input  logic          rst_n,
    accel_run_ctrl_if.slave bus
);
    localparam int SW = (SRST_CYCLES > 1) ? $clog2(SRST_CYCLES) : 1;

    if (SRST_CYCLES < 1 || WDOG_LIMIT < 1) begin : g_bad_param
        $error("accel_run_ctrl: SRST_CYCLES and WDOG_LIMIT must be >= 1");
    end

    state_e                state_q, state_d;
    logic [PASS_WIDTH-1:0] num_q, num_d, pass_q, pass_d, pass_inc_s;
    logic [SW-1:0]         srst_cnt_q, srst_cnt_d;
    logic                  kflag_q, kflag_d, pflag_q, pflag_d;
    logic                  done_st_q, done_st_d, abort_st_q, abort_st_d, tmo_st_q, tmo_st_d;
    logic [REG_WIDTH-1:0]  ctrl_q, ctrl_d, status_q, status_d;
    logic                  busy_q, busy_d, done_q, done_d, irq_q, irq_d;
    logic                  start_ok_s, abort_s, both_s, wdog_exp_s, irq_set_s;
    logic [1:0]            cb_s;

    assign start_ok_s = (state_q == ST_IDLE) && bus.i_start && !bus.i_abort;
    assign abort_s    = (state_q != ST_IDLE) && (state_q != ST_ABORT) && bus.i_abort;
    assign both_s     = (kflag_q || bus.i_kcpe_done) && (pflag_q || bus.i_psum_done);
    assign pass_inc_s = pass_q + PASS_WIDTH'(1);

`ifdef ACCEL_RUN_CTRL_WATCHDOG_EN
    accel_wdog_cnt #(.LIMIT(WDOG_LIMIT)) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_q != ST_RUN),
        .en_i     (state_q == ST_RUN),
        .expire_o (wdog_exp_s)
    );
`else
    assign wdog_exp_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a host abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (abort_s) begin
            state_d = ST_ABORT;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = !start_ok_s ? ST_IDLE :
                                    (bus.i_num_pass == {PASS_WIDTH{1'b0}}) ? ST_FIN : ST_SRST;
                ST_SRST:  state_d = (srst_cnt_q == SW'(SRST_CYCLES - 1)) ? ST_RUN : ST_SRST;
                ST_RUN:   state_d = both_s ? ST_DRAIN : (wdog_exp_s ? ST_ABORT : ST_RUN);
                ST_DRAIN: state_d = ST_NEXT;
                ST_NEXT:  state_d = (pass_inc_s == num_q) ? ST_FIN : ST_SRST;
                ST_FIN:   state_d = ST_IDLE;
                ST_ABORT: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Output/datapath next values, decoded from the upcoming state so outputs align with it.
    always_comb begin
        num_d      = num_q;
        pass_d     = pass_q;
        done_st_d  = done_st_q;
        abort_st_d = abort_st_q;
        tmo_st_d   = tmo_st_q;
        if (start_ok_s) begin
            num_d      = bus.i_num_pass;
            pass_d     = {PASS_WIDTH{1'b0}};
            done_st_d  = 1'b0;
            abort_st_d = 1'b0;
            tmo_st_d   = 1'b0;
        end else if (state_q == ST_NEXT && state_d == ST_SRST) begin
            pass_d = pass_inc_s;
        end else begin
            pass_d = pass_q;
        end
        if (state_d == ST_FIN) begin
            done_st_d = 1'b1;
        end else if (state_d == ST_ABORT) begin
            abort_st_d = 1'b1;
            tmo_st_d   = tmo_st_q || ((state_q == ST_RUN) && !bus.i_abort);
        end else begin
            done_st_d = done_st_d;
        end

        kflag_d    = (state_q == ST_RUN) && (kflag_q || bus.i_kcpe_done);
        pflag_d    = (state_q == ST_RUN) && (pflag_q || bus.i_psum_done);
        srst_cnt_d = (state_q == ST_SRST) ? srst_cnt_q + SW'(1) : {SW{1'b0}};

        // Set holds across the whole FIN/ABORT cycle so a coincident clear cannot drop it.
        irq_set_s = (state_d == ST_FIN) || (state_d == ST_ABORT) ||
                    (state_q == ST_FIN) || (state_q == ST_ABORT);
        if (irq_set_s) begin
            irq_d = 1'b1;
        end else if (bus.i_irq_clr) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end

        cb_s              = ctrl_bits(state_d);
        ctrl_d            = {REG_WIDTH{1'b0}};
        ctrl_d[CTRL_EN]   = cb_s[0];
        ctrl_d[CTRL_SRST] = cb_s[1];
        busy_d            = (state_d != ST_IDLE);
        done_d            = (state_d == ST_FIN);

        status_d                                = {REG_WIDTH{1'b0}};
        status_d[STAT_BUSY]                     = busy_d;
        status_d[STAT_DONE]                     = done_st_d;
        status_d[STAT_ABORT]                    = abort_st_d;
        status_d[STAT_TMO]                      = tmo_st_d;
        status_d[STAT_PASS_LSB +: PASS_WIDTH]   = pass_d;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q      <= {PASS_WIDTH{1'b0}};
            pass_q     <= {PASS_WIDTH{1'b0}};
            srst_cnt_q <= {SW{1'b0}};
            kflag_q    <= 1'b0;
            pflag_q    <= 1'b0;
            done_st_q  <= 1'b0;
            abort_st_q <= 1'b0;
            tmo_st_q   <= 1'b0;
            ctrl_q     <= {REG_WIDTH{1'b0}};
            status_q   <= {REG_WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            num_q      <= num_d;
            pass_q     <= pass_d;
            srst_cnt_q <= srst_cnt_d;
            kflag_q    <= kflag_d;
            pflag_q    <= pflag_d;
            done_st_q  <= done_st_d;
            abort_st_q <= abort_st_d;
            tmo_st_q   <= tmo_st_d;
            ctrl_q     <= ctrl_d;
            status_q   <= status_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.o_conf_ctrl = ctrl_q;
    assign bus.o_pass_idx  = pass_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_irq       = irq_q;
    assign bus.o_status    = status_q;
endmodule

// File: tb/tb_accel_run_ctrl.sv
// Scoreboard bench for accel_run_ctrl: job results queued at start, checked when the job ends.
module tb_accel_run_ctrl;
    localparam int REG_W  = 32;
    localparam int PASS_W = 16;
    localparam int SRST_C = 2;
    localparam int WDOG_L = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    accel_run_ctrl_if #(.REG_WIDTH(REG_W), .PASS_WIDTH(PASS_W)) bus ();

    accel_run_ctrl #(
        .REG_WIDTH(REG_W), .PASS_WIDTH(PASS_W), .SRST_CYCLES(SRST_C), .WDOG_LIMIT(WDOG_L)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] status;
        logic        irq;
        int          dones;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_seen = 0;

    always @(posedge clk) begin
        if (bus.o_done === 1'b1) done_seen <= done_seen + 1;
    end

    initial begin
        #200000;
        $display("FAIL tb_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_irq();
        bus.i_irq_clr = 1'b1;
        step();
        bus.i_irq_clr = 1'b0;
        n_tests++;
        if (bus.o_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_clr: o_irq=%b required 0", bus.o_irq);
        end
    endtask

    task automatic start_job(input int num, input logic [31:0] status, input int dones);
        exp_t e;
        e.status = status;
        e.irq    = 1'b1;
        e.dones  = done_seen + dones;
        exp_q.push_back(e);
        bus.i_num_pass = PASS_W'(num);
        bus.i_start    = 1'b1;
        step();
        bus.i_start    = 1'b0;
    endtask

    task automatic finish_job(input string name);
        exp_t e;
        int   guard = 0;
        while (bus.o_busy !== 1'b0 && guard < 20) begin
            step();
            guard++;
        end
        n_tests++;
        if (bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s job_end: o_busy=%b required 0 within 20 cycles", name, bus.o_busy);
        end
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard: queue empty, required one entry", name);
        end else begin
            e = exp_q.pop_front();
            n_tests++;
            if (bus.o_status !== e.status) begin
                n_fail++;
                $display("FAIL %s status: got %h required %h", name, bus.o_status, e.status);
            end
            n_tests++;
            if (bus.o_irq !== e.irq) begin
                n_fail++;
                $display("FAIL %s irq: got %b required %b", name, bus.o_irq, e.irq);
            end
            n_tests++;
            if (done_seen != e.dones) begin
                n_fail++;
                $display("FAIL %s done_pulses: got %0d required %0d", name, done_seen, e.dones);
            end
        end
    endtask

    task automatic enter_run(input string name, output int srst_len);
        int guard = 0;
        srst_len = 0;
        while (bus.o_conf_ctrl !== 32'h2 && guard < 8) begin
            step();
            guard++;
        end
        while (bus.o_conf_ctrl === 32'h2 && guard < 20) begin
            srst_len++;
            step();
            guard++;
        end
        n_tests++;
        if (bus.o_conf_ctrl !== 32'h1) begin
            n_fail++;
            $display("FAIL %s run_entry: ctrl=%h required 00000001", name, bus.o_conf_ctrl);
        end
    endtask

    task automatic run_pass(input string name, input int k_a, input int k_b, input int exp_drain);
        for (int k = 0; k <= exp_drain; k++) begin
            if (k == exp_drain - 1) begin
                n_tests++;
                if (bus.o_conf_ctrl !== 32'h1) begin
                    n_fail++;
                    $display("FAIL %s run_hold k=%0d: ctrl=%h required 00000001", name, k, bus.o_conf_ctrl);
                end
            end
            if (k == exp_drain) begin
                bus.i_kcpe_done = 1'b0;
                bus.i_psum_done = 1'b0;
                n_tests++;
                if (bus.o_conf_ctrl !== 32'h0 || bus.o_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s drain k=%0d: ctrl=%h busy=%b required 00000000 1",
                             name, k, bus.o_conf_ctrl, bus.o_busy);
                end
            end else begin
                bus.i_kcpe_done = (k == k_a);
                bus.i_psum_done = (k == k_b);
                step();
            end
        end
    endtask

    task automatic test_reset();
        step();
        step();
        n_tests++;
        if ({bus.o_conf_ctrl, bus.o_status, bus.o_pass_idx, bus.o_busy, bus.o_done, bus.o_irq} !== 83'd0) begin
            n_fail++;
            $display("FAIL reset_hold: ctrl=%h status=%h pass=%h busy=%b done=%b irq=%b required all 0",
                     bus.o_conf_ctrl, bus.o_status, bus.o_pass_idx, bus.o_busy, bus.o_done, bus.o_irq);
        end
        rst_n = 1'b1;
        step();
        step();
        n_tests++;
        if (bus.o_busy !== 1'b0 || bus.o_conf_ctrl !== 32'h0 || bus.o_status !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b ctrl=%h status=%h required 0 0 0",
                     bus.o_busy, bus.o_conf_ctrl, bus.o_status);
        end
    endtask

    task automatic test_multi_pass();
        int len;
        start_job(3, 32'h0002_0002, 1);
        for (int p = 0; p < 3; p++) begin
            enter_run("multi", len);
            n_tests++;
            if (len != SRST_C) begin
                n_fail++;
                $display("FAIL multi srst_len pass %0d: got %0d required %0d", p, len, SRST_C);
            end
            n_tests++;
            if (bus.o_pass_idx !== PASS_W'(p)) begin
                n_fail++;
                $display("FAIL multi pass_idx: got %0d required %0d", bus.o_pass_idx, p);
            end
            run_pass("multi", 10, 10, 11);
        end
        finish_job("multi");
    endtask

    task automatic test_done_order();
        int len;
        clear_irq();
        bus.i_kcpe_done = 1'b1;
        bus.i_psum_done = 1'b1;
        start_job(1, 32'h0000_0002, 1);
        enter_run("order_split", len);
        run_pass("order_split", 5, 9, 10);
        finish_job("order_split");
        start_job(1, 32'h0000_0002, 1);
        enter_run("order_same", len);
        run_pass("order_same", 3, 3, 4);
        finish_job("order_same");
    endtask

    task automatic test_abort();
        int len;
        clear_irq();
        start_job(3, 32'h0001_0004, 0);
        enter_run("abort", len);
        run_pass("abort", 2, 2, 3);
        enter_run("abort", len);
        repeat (3) step();
        bus.i_abort = 1'b1;
        step();
        bus.i_abort = 1'b0;
        n_tests++;
        if (bus.o_conf_ctrl !== 32'h2 || bus.o_busy !== 1'b1 || bus.o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: ctrl=%h busy=%b done=%b required 00000002 1 0",
                     bus.o_conf_ctrl, bus.o_busy, bus.o_done);
        end
        step();
        n_tests++;
        if (bus.o_busy !== 1'b0 || bus.o_pass_idx !== 16'd1) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b pass=%0d required 0 1", bus.o_busy, bus.o_pass_idx);
        end
        finish_job("abort");
    endtask

    task automatic test_zero_pass();
        clear_irq();
        start_job(0, 32'h0000_0002, 1);
        n_tests++;
        if (bus.o_done !== 1'b1 || bus.o_conf_ctrl !== 32'h0 || bus.o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_fin: done=%b ctrl=%h busy=%b required 1 00000000 1",
                     bus.o_done, bus.o_conf_ctrl, bus.o_busy);
        end
        step();
        n_tests++;
        if (bus.o_conf_ctrl !== 32'h0 || bus.o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_after: ctrl=%h done=%b required 00000000 0", bus.o_conf_ctrl, bus.o_done);
        end
        finish_job("zero");
    endtask

    task automatic test_ignore();
        int len;
        bus.i_num_pass = 16'd2;
        bus.i_start    = 1'b1;
        bus.i_abort    = 1'b1;
        step();
        bus.i_start    = 1'b0;
        bus.i_abort    = 1'b0;
        n_tests++;
        if (bus.o_busy !== 1'b0 || bus.o_conf_ctrl !== 32'h0) begin
            n_fail++;
            $display("FAIL start_abort_idle: busy=%b ctrl=%h required 0 00000000", bus.o_busy, bus.o_conf_ctrl);
        end
        start_job(1, 32'h0000_0002, 1);
        bus.i_num_pass = 16'd5;
        bus.i_start    = 1'b1;
        step();
        bus.i_start    = 1'b0;
        enter_run("busy_start", len);
        run_pass("busy_start", 0, 0, 1);
        finish_job("busy_start");
        clear_irq();
        start_job(0, 32'h0000_0002, 1);
        bus.i_irq_clr = 1'b1;
        step();
        bus.i_irq_clr = 1'b0;
        n_tests++;
        if (bus.o_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_set_wins: o_irq=%b required 1", bus.o_irq);
        end
        finish_job("irq_clr_fin");
        clear_irq();
    endtask

    task automatic test_watchdog();
        int len;
        clear_irq();
`ifdef ACCEL_RUN_CTRL_WATCHDOG_EN
        start_job(1, 32'h0000_000C, 0);
        enter_run("wdog", len);
        for (int k = 0; k <= WDOG_L; k++) begin
            if (k == WDOG_L - 1) begin
                n_tests++;
                if (bus.o_conf_ctrl !== 32'h1) begin
                    n_fail++;
                    $display("FAIL wdog_run k=%0d: ctrl=%h required 00000001", k, bus.o_conf_ctrl);
                end
            end
            if (k == WDOG_L) begin
                n_tests++;
                if (bus.o_conf_ctrl !== 32'h2) begin
                    n_fail++;
                    $display("FAIL wdog_abort: ctrl=%h required 00000002", bus.o_conf_ctrl);
                end
            end else begin
                step();
            end
        end
        step();
`else
        start_job(1, 32'h0000_0004, 0);
        enter_run("no_wdog", len);
        repeat (40) step();
        n_tests++;
        if (bus.o_conf_ctrl !== 32'h1 || bus.o_status !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL no_wdog_wait: ctrl=%h status=%h required 00000001 00000001",
                     bus.o_conf_ctrl, bus.o_status);
        end
        bus.i_abort = 1'b1;
        step();
        bus.i_abort = 1'b0;
        step();
`endif
        finish_job("wdog");
    endtask

    task automatic test_reset_mid_run();
        int len;
        bus.i_num_pass = 16'd3;
        bus.i_start    = 1'b1;
        step();
        bus.i_start    = 1'b0;
        enter_run("rst_mid", len);
        run_pass("rst_mid", 1, 1, 2);
        enter_run("rst_mid", len);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.o_conf_ctrl, bus.o_status, bus.o_pass_idx, bus.o_busy, bus.o_done, bus.o_irq} !== 83'd0) begin
            n_fail++;
            $display("FAIL rst_mid_async: ctrl=%h status=%h pass=%h busy=%b done=%b irq=%b required all 0",
                     bus.o_conf_ctrl, bus.o_status, bus.o_pass_idx, bus.o_busy, bus.o_done, bus.o_irq);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        n_tests++;
        if (bus.o_busy !== 1'b0 || bus.o_irq !== 1'b0 || bus.o_conf_ctrl !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_after: busy=%b irq=%b ctrl=%h required 0 0 00000000",
                     bus.o_busy, bus.o_irq, bus.o_conf_ctrl);
        end
    endtask

    initial begin
        bus.i_start     = 1'b0;
        bus.i_abort     = 1'b0;
        bus.i_num_pass  = 16'd0;
        bus.i_kcpe_done = 1'b0;
        bus.i_psum_done = 1'b0;
        bus.i_irq_clr   = 1'b0;
        test_reset();
        test_multi_pass();
        test_done_order();
        test_abort();
        test_zero_pass();
        test_ignore();
        test_watchdog();
        test_reset_mid_run();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
